// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM state type and default sizing for the DVP capture block.
//   No ports; imported by cam_sync_edge and cam_dvp_capture.
package cam_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, FRAME} state_t;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_X_W = 10;
    localparam int DEF_Y_W = 9;
endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: N-stage synchronizer for one camera control line plus edge detect.
//   clk    in  sampling clock
//   rst_n  in  asynchronous active-low reset
//   din    in  asynchronous pin
//   lvl    out synchronized level
//   rise   out lvl went 0->1 this cycle
//   fall   out lvl went 1->0 this cycle
module cam_sync_edge
    import cam_pkg::*;
#(
    parameter int N       = DEF_SYNC_STAGES,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic [N-1:0] chain;
    logic         prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {N{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[N-2:0], din};
            prev  <= chain[N-1];
        end
    end

    assign lvl  = chain[N-1];
    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;
endmodule

// File: rtl/cam_dvp_capture.sv
// cam_dvp_capture: oversampled 8-bit DVP capture, byte pairs -> 16-bit x/y-tagged pixel stream.
//   CLOCK, RESET_N              sole clock, asynchronous active-low reset
//   cam_pclk/vsync/href/d       raw camera pins, sampled as data
//   enable                      capture enable (level)
//   pix_data/x/y/sof/valid      one-entry output register, pix_ready accepts
//   line_done, frame_done       1-cycle pulses at line / frame end inside a frame
//   overflow                    sticky: a pixel arrived while the output was stalled
module cam_dvp_capture
    import cam_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter bit VSYNC_POL   = 1'b1
) (
    input  logic           CLOCK,
    input  logic           RESET_N,
    input  logic           cam_pclk,
    input  logic           cam_vsync,
    input  logic           cam_href,
    input  logic [7:0]     cam_d,
    input  logic           enable,
    output logic [15:0]    pix_data,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           pix_sof,
    output logic           pix_valid,
    input  logic           pix_ready,
    output logic           line_done,
    output logic           frame_done,
    output logic           overflow
);
    localparam logic [X_W-1:0] X_MAX = '1;
    localparam logic [Y_W-1:0] Y_MAX = '1;

    logic pclk_lvl, pclk_rise, pclk_fall;
    logic href_lvl, href_rise, href_fall;
    logic vs_lvl, vs_rise, vs_fall;
    logic unused_edges;

    cam_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_pclk (
        .clk(CLOCK), .rst_n(RESET_N), .din(cam_pclk),
        .lvl(pclk_lvl), .rise(pclk_rise), .fall(pclk_fall)
    );
    cam_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_href (
        .clk(CLOCK), .rst_n(RESET_N), .din(cam_href),
        .lvl(href_lvl), .rise(href_rise), .fall(href_fall)
    );
    // VSYNC resets to its non-blanking level so a pin already in blanking after
    // reset is never mistaken for a frame start.
    cam_sync_edge #(.N(SYNC_STAGES), .RST_VAL(!VSYNC_POL)) u_vsync (
        .clk(CLOCK), .rst_n(RESET_N), .din(cam_vsync),
        .lvl(vs_lvl), .rise(vs_rise), .fall(vs_fall)
    );

    assign unused_edges = &{1'b0, pclk_lvl, pclk_fall, href_rise, vs_lvl};

    // Data chain has the same depth as the control chains so d is aligned with pclk rise.
    logic [7:0] d_chain [SYNC_STAGES];
    logic [7:0] d_s;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) d_chain[i] <= '0;
        end else begin
            d_chain[0] <= cam_d;
            for (int i = 1; i < SYNC_STAGES; i++) d_chain[i] <= d_chain[i-1];
        end
    end

    assign d_s = d_chain[SYNC_STAGES-1];

    logic blank_enter, blank_leave;
    assign blank_enter = VSYNC_POL ? vs_rise : vs_fall;
    assign blank_leave = VSYNC_POL ? vs_fall : vs_rise;

    state_t         state;
    logic [X_W-1:0] x, px_x;
    logic [Y_W-1:0] y, px_y;
    logic           phase, px_stb, px_sof;
    logic [7:0]     hi;
    logic [15:0]    px_word;

    // Capture FSM; px_* is a one-cycle strobe carrying each freshly formed pixel.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            phase      <= 1'b0;
            hi         <= '0;
            px_stb     <= 1'b0;
            px_word    <= '0;
            px_x       <= '0;
            px_y       <= '0;
            px_sof     <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            px_stb     <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                phase <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_FRAME;
                    WAIT_FRAME: begin
                        if (blank_leave) begin
                            state <= FRAME;
                            x     <= '0;
                            y     <= '0;
                            phase <= 1'b0;
                        end
                    end
                    FRAME: begin
                        // Blanking wins over any byte arriving in the same cycle.
                        if (blank_enter) begin
                            frame_done <= 1'b1;
                            state      <= WAIT_FRAME;
                        end else if (pclk_rise && href_lvl) begin
                            phase <= ~phase;
                            if (!phase) begin
                                hi <= d_s;
                            end else begin
                                px_stb  <= 1'b1;
                                px_word <= {hi, d_s};
                                px_x    <= x;
                                px_y    <= y;
                                px_sof  <= (x == '0) && (y == '0);
                                x       <= (x == X_MAX) ? x : x + 1'b1;
                            end
                        end
                        if (href_fall) begin
                            line_done <= 1'b1;
                            y         <= (y == Y_MAX) ? y : y + 1'b1;
                            x         <= '0;
                            phase     <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic ovf_clr;
    assign ovf_clr = (state == IDLE) && enable;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_sof   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (px_stb && (!pix_valid || pix_ready)) begin
                pix_valid <= 1'b1;
                pix_data  <= px_word;
                pix_x     <= px_x;
                pix_y     <= px_y;
                pix_sof   <= px_sof;
            end else if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
            end
            overflow <= ovf_clr ? 1'b0 : (overflow | (px_stb & pix_valid & ~pix_ready));
        end
    end
endmodule

// File: tb/tb_cam_dvp_capture.sv
// tb_cam_dvp_capture: randomized self-checking bench for cam_dvp_capture against a frame-level pixel model.
module tb_cam_dvp_capture;
    localparam int SS   = 2;
    localparam int XW   = 2;
    localparam int YW   = 2;
    localparam int XMAX = (1 << XW) - 1;
    localparam int YMAX = (1 << YW) - 1;

    typedef struct packed {
        logic [15:0]   d;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          sof;
    } pix_t;

    logic          CLOCK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_d = '0;
    logic          enable = 1'b0;
    logic          pix_ready = 1'b0;
    logic [15:0]   pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_sof, pix_valid, line_done, frame_done, overflow;

    int tests = 0;
    int fails = 0;
    int line_cnt = 0;
    int frame_cnt = 0;
    pix_t got[$];
    pix_t exp_q[$];

    always #5 CLOCK = ~CLOCK;

    cam_dvp_capture #(.SYNC_STAGES(SS), .X_W(XW), .Y_W(YW), .VSYNC_POL(1'b1)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_d(cam_d), .enable(enable), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .line_done(line_done), .frame_done(frame_done),
        .overflow(overflow)
    );

    // Monitor samples mid-cycle, well away from the rising edge.
    always begin
        @(negedge CLOCK);
        #2;
        if (RESET_N) begin
            if (pix_valid && pix_ready) got.push_back({pix_data, pix_x, pix_y, pix_sof});
            line_cnt  += int'(line_done);
            frame_cnt += int'(frame_done);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic int first_diff();
        if (got.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic clear_obs();
        got.delete();
        exp_q.delete();
        line_cnt  = 0;
        frame_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    // One byte at pclk = CLOCK/4: two cycles low with data set, two cycles high.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK);
        cam_pclk = 1'b0;
        cam_d    = b;
        idle(2);
        cam_pclk = 1'b1;
        @(negedge CLOCK);
    endtask

    task automatic blank(input logic on);
        @(negedge CLOCK);
        cam_vsync = on;
        idle(8);
    endtask

    // Reference model: pixel k of line l is {b[2k], b[2k+1]} at saturated (k, l); odd tail byte ignored.
    task automatic send_line(input int nb, input int l, input bit model);
        logic [7:0] b[$];
        pix_t p;
        for (int i = 0; i < nb; i++) b.push_back(8'($urandom));
        if (model) begin
            for (int k = 0; k < nb / 2; k++) begin
                p.d   = {b[2*k], b[2*k+1]};
                p.x   = XW'(k > XMAX ? XMAX : k);
                p.y   = YW'(l > YMAX ? YMAX : l);
                p.sof = (k == 0) && (l == 0);
                exp_q.push_back(p);
            end
        end
        @(negedge CLOCK);
        cam_href = 1'b1;
        foreach (b[i]) send_byte(b[i]);
        @(negedge CLOCK);
        cam_href = 1'b0;
        cam_pclk = 1'b0;
        idle(8);
    endtask

    task automatic run_frame(input int nl, input int nb0, input int nb);
        blank(1'b1);
        blank(1'b0);
        for (int l = 0; l < nl; l++) send_line(l == 0 ? nb0 : nb, l, 1'b1);
        blank(1'b1);
        idle(6);
    endtask

    task automatic test_reset();
        idle(3);
        @(posedge CLOCK);
        #1;
        tests++;
        if ({pix_valid, pix_data, pix_x, pix_y, pix_sof, line_done, frame_done, overflow} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {pix_valid, pix_data, pix_x, pix_y, pix_sof, line_done, frame_done, overflow});
        end
        @(negedge CLOCK);
        RESET_N = 1'b1;
        idle(4);
        tests++;
        if ({pix_valid, overflow, line_done, frame_done} !== 4'b0) begin
            fails++;
            $display("FAIL idle_outputs: got %b expected 0000", {pix_valid, overflow, line_done, frame_done});
        end
    endtask

    task automatic test_frame();
        int d;
        clear_obs();
        pix_ready = 1'b1;
        enable    = 1'b1;
        idle(4);
        run_frame(2, 8, 8);
        d = first_diff();
        tests++;
        if (d != -1) begin
            fails++;
            $display("FAIL frame_pixels: got %0d pixels expected %0d, first diff %0d", got.size(), exp_q.size(), d);
        end
        tests++;
        if (line_cnt != 2 || frame_cnt != 1) begin
            fails++;
            $display("FAIL frame_pulses: got lines %0d frames %0d expected 2 and 1", line_cnt, frame_cnt);
        end
    endtask

    task automatic test_latency();
        int lat = 0;
        clear_obs();
        blank(1'b1);
        blank(1'b0);
        @(negedge CLOCK);
        cam_href = 1'b1;
        send_byte(8'hAB);
        @(negedge CLOCK);
        cam_pclk = 1'b0;
        cam_d    = 8'hCD;
        idle(2);
        cam_pclk = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge CLOCK);
            #1;
            if (pix_valid) begin
                lat = i;
                break;
            end
        end
        tests++;
        if (lat != SS + 2) begin
            fails++;
            $display("FAIL latency: got %0d cycles expected %0d", lat, SS + 2);
        end
        tests++;
        if (pix_data !== 16'hABCD || pix_sof !== 1'b1) begin
            fails++;
            $display("FAIL latency_data: got %h sof %b expected abcd sof 1", pix_data, pix_sof);
        end
        @(negedge CLOCK);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        idle(8);
        blank(1'b1);
    endtask

    task automatic test_stall();
        logic [7:0] b[6];
        clear_obs();
        pix_ready = 1'b0;
        foreach (b[i]) b[i] = 8'($urandom);
        blank(1'b1);
        blank(1'b0);
        @(negedge CLOCK);
        cam_href = 1'b1;
        foreach (b[i]) send_byte(b[i]);
        @(negedge CLOCK);
        cam_href = 1'b0;
        cam_pclk = 1'b0;
        idle(8);
        tests++;
        if (pix_valid !== 1'b1 || pix_data !== {b[0], b[1]} || overflow !== 1'b1) begin
            fails++;
            $display("FAIL stall_hold: got valid %b data %h ovf %b expected 1 %h 1",
                     pix_valid, pix_data, overflow, {b[0], b[1]});
        end
        @(negedge CLOCK);
        pix_ready = 1'b1;
        @(posedge CLOCK);
        #1;
        tests++;
        if (pix_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_drain: got valid %b expected 0", pix_valid);
        end
        tests++;
        if (got.size() != 1 || got[0].d !== {b[0], b[1]}) begin
            fails++;
            $display("FAIL stall_accept: got %0d pixels expected 1 of %h", got.size(), {b[0], b[1]});
        end
        blank(1'b1);
    endtask

    task automatic test_odd_line();
        int d;
        clear_obs();
        run_frame(2, 5, 4);
        d = first_diff();
        tests++;
        if (d != -1) begin
            fails++;
            $display("FAIL odd_pixels: got %0d pixels expected %0d, first diff %0d", got.size(), exp_q.size(), d);
        end
        tests++;
        if (line_cnt != 2) begin
            fails++;
            $display("FAIL odd_lines: got %0d expected 2", line_cnt);
        end
    endtask

    task automatic test_saturate();
        int d;
        clear_obs();
        run_frame(5, 12, 12);
        d = first_diff();
        tests++;
        if (d != -1) begin
            fails++;
            $display("FAIL sat_pixels: got %0d pixels expected %0d, first diff %0d", got.size(), exp_q.size(), d);
        end
        tests++;
        if (line_cnt != 5 || frame_cnt != 1) begin
            fails++;
            $display("FAIL sat_pulses: got lines %0d frames %0d expected 5 and 1", line_cnt, frame_cnt);
        end
    endtask

    task automatic test_disable();
        logic [7:0] b[6];
        int d;
        clear_obs();
        pix_ready = 1'b0;
        foreach (b[i]) b[i] = 8'($urandom);
        blank(1'b1);
        blank(1'b0);
        @(negedge CLOCK);
        cam_href = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(b[i]);
        idle(6);
        @(negedge CLOCK);
        enable = 1'b0;
        @(posedge CLOCK);
        #1;
        tests++;
        if (pix_valid !== 1'b1 || pix_data !== {b[0], b[1]}) begin
            fails++;
            $display("FAIL dis_held: got valid %b data %h expected 1 %h", pix_valid, pix_data, {b[0], b[1]});
        end
        for (int i = 3; i < 6; i++) send_byte(b[i]);
        @(negedge CLOCK);
        cam_href = 1'b0;
        cam_pclk = 1'b0;
        idle(6);
        blank(1'b1);
        tests++;
        if (line_cnt != 0 || frame_cnt != 0) begin
            fails++;
            $display("FAIL dis_pulses: got lines %0d frames %0d expected 0 and 0", line_cnt, frame_cnt);
        end
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL dis_ovf_sticky: got %b expected 1", overflow);
        end
        @(negedge CLOCK);
        pix_ready = 1'b1;
        idle(4);
        got.delete();
        blank(1'b0);
        @(negedge CLOCK);
        enable = 1'b1;
        idle(4);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL reenable_ovf_clear: got %b expected 0", overflow);
        end
        send_line(4, 0, 1'b0);
        blank(1'b1);
        tests++;
        if (got.size() != 0 || frame_cnt != 0) begin
            fails++;
            $display("FAIL reenable_wait: got %0d pixels %0d frames expected 0 and 0", got.size(), frame_cnt);
        end
        clear_obs();
        run_frame(1, 4, 4);
        d = first_diff();
        tests++;
        if (d != -1 || frame_cnt != 1) begin
            fails++;
            $display("FAIL reenable_frame: got %0d pixels %0d frames expected %0d and 1",
                     got.size(), frame_cnt, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        int d;
        clear_obs();
        pix_ready = 1'b0;
        blank(1'b1);
        blank(1'b0);
        @(negedge CLOCK);
        cam_href = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        idle(4);
        tests++;
        if ({pix_valid, overflow} !== 2'b11) begin
            fails++;
            $display("FAIL prereset_state: got %b expected 11", {pix_valid, overflow});
        end
        @(negedge CLOCK);
        #3;
        RESET_N = 1'b0;
        #1;
        tests++;
        if ({pix_valid, pix_data, pix_x, pix_y, pix_sof, line_done, frame_done, overflow} !== '0) begin
            fails++;
            $display("FAIL async_reset: got %h expected 0",
                     {pix_valid, pix_data, pix_x, pix_y, pix_sof, line_done, frame_done, overflow});
        end
        @(negedge CLOCK);
        RESET_N   = 1'b1;
        pix_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        @(negedge CLOCK);
        cam_href = 1'b0;
        cam_pclk = 1'b0;
        idle(8);
        blank(1'b1);
        tests++;
        if (got.size() != 0 || frame_cnt != 0) begin
            fails++;
            $display("FAIL postreset_wait: got %0d pixels %0d frames expected 0 and 0", got.size(), frame_cnt);
        end
        clear_obs();
        run_frame(2, 4, 4);
        d = first_diff();
        tests++;
        if (d != -1) begin
            fails++;
            $display("FAIL postreset_frame: got %0d pixels expected %0d, first diff %0d", got.size(), exp_q.size(), d);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_latency();
        test_stall();
        test_odd_line();
        test_saturate();
        test_disable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
